// File: rtl/harbinger_pkg.sv
// Shared constants and FSM state type for the synth parameter bank.
package harbinger_pkg;

  localparam int unsigned NPARAM   = 75;
  localparam int unsigned TRIG_IDX = 74;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 7;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned TRIG_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/param_bank_if.sv
// SPI word stream in, parameter read port and frame status out.
interface param_bank_if;
  import harbinger_pkg::*;

  logic [DATA_W-1:0] synth_data;
  logic              data_valid;
  logic              read_data;
  logic              busy;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [TRIG_W-1:0] trig;
  logic              commit;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output synth_data, data_valid, busy, rd_addr,
    input  read_data, rd_data, trig, commit, frame_err, frame_cnt
  );

  modport slave (
    input  synth_data, data_valid, busy, rd_addr,
    output read_data, rd_data, trig, commit, frame_err, frame_cnt
  );

endinterface

// File: rtl/param_ram.sv
// Two-bank parameter store: one write port, one registered read port.
module param_ram
  import harbinger_pkg::*;
#(
  parameter int unsigned NWORDS = NPARAM
) (
  input  logic              clk24,
  input  logic              rst,
  input  logic              we,
  input  logic              wbank,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  input  logic              rbank,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2][NWORDS];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk24) begin
    if (we && (widx < IDX_W'(NWORDS))) mem[wbank][widx] <= wdata;
  end

  // ren low forces zero so stale contents never reach the port
  always_comb begin
    rdata_d = '0;
    if (ren && (ridx < IDX_W'(NWORDS))) rdata_d = mem[rbank][ridx];
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_bank.sv
// Double-buffered parameter frame capture: fills the shadow bank from the
// SPI word stream and swaps banks atomically when a complete frame lands.
module param_bank
  import harbinger_pkg::*;
#(
  parameter int unsigned NPARAM   = harbinger_pkg::NPARAM,
  parameter int unsigned TRIG_IDX = harbinger_pkg::TRIG_IDX
) (
  input logic         clk24,
  input logic         rst,
  param_bank_if.slave bus
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wcnt_q, wcnt_d;
  logic              bank_sel_q, bank_sel_d;
  logic              loaded_q, loaded_d;
  logic              busy_q;
  logic              read_data_q, read_data_d;
  logic              drop_q, drop_d;
  logic              commit_q, commit_d;
  logic              err_q, err_d;
  logic [TRIG_W-1:0] shadow_trig_q, shadow_trig_d;
  logic [TRIG_W-1:0] trig_q, trig_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic accept, busy_fall, wr_en, complete;

  assign accept    = bus.data_valid & read_data_q;
  assign busy_fall = busy_q & ~bus.busy;
  assign wr_en     = accept & (state_q != DRAIN);
  assign complete  = wr_en & (wcnt_q == IDX_W'(NPARAM - 1));

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A word on the busy-fall cycle is processed before the fall is judged
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, FILL: begin
        if (complete)       state_d = bus.busy ? DRAIN : IDLE;
        else if (busy_fall) state_d = IDLE;
        else if (wr_en)     state_d = FILL;
      end
      DRAIN:   if (busy_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_data_d   = 1'b1;
    wcnt_d        = wcnt_q;
    drop_d        = drop_q;
    commit_d      = 1'b0;
    err_d         = 1'b0;
    bank_sel_d    = bank_sel_q;
    loaded_d      = loaded_q;
    frame_cnt_d   = frame_cnt_q;
    shadow_trig_d = shadow_trig_q;
    trig_d        = trig_q;

    if (wr_en && (wcnt_q == IDX_W'(TRIG_IDX))) shadow_trig_d = bus.synth_data[TRIG_W-1:0];

    unique case (state_q)
      IDLE, FILL: begin
        if (complete) begin
          wcnt_d      = '0;
          commit_d    = 1'b1;
          bank_sel_d  = ~bank_sel_q;
          loaded_d    = 1'b1;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          trig_d      = shadow_trig_d;
        end else if (busy_fall) begin
          err_d  = wr_en | (wcnt_q != '0);
          wcnt_d = '0;
        end else if (wr_en) begin
          wcnt_d = wcnt_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (busy_fall) begin
          err_d  = drop_q | accept;
          drop_d = 1'b0;
        end else if (accept) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        wcnt_d = '0;
        drop_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      wcnt_q        <= '0;
      bank_sel_q    <= 1'b0;
      loaded_q      <= 1'b0;
      busy_q        <= 1'b0;
      read_data_q   <= 1'b0;
      drop_q        <= 1'b0;
      commit_q      <= 1'b0;
      err_q         <= 1'b0;
      shadow_trig_q <= '0;
      trig_q        <= '0;
      frame_cnt_q   <= '0;
    end else begin
      wcnt_q        <= wcnt_d;
      bank_sel_q    <= bank_sel_d;
      loaded_q      <= loaded_d;
      busy_q        <= bus.busy;
      read_data_q   <= read_data_d;
      drop_q        <= drop_d;
      commit_q      <= commit_d;
      err_q         <= err_d;
      shadow_trig_q <= shadow_trig_d;
      trig_q        <= trig_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  param_ram #(.NWORDS(NPARAM)) u_ram (
    .clk24 (clk24),
    .rst   (rst),
    .we    (wr_en),
    .wbank (~bank_sel_q),
    .widx  (wcnt_q),
    .wdata (bus.synth_data),
    .ren   (loaded_q),
    .rbank (bank_sel_q),
    .ridx  (bus.rd_addr),
    .rdata (bus.rd_data)
  );

  assign bus.read_data = read_data_q;
  assign bus.trig      = trig_q;
  assign bus.commit    = commit_q;
  assign bus.frame_err = err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
